output_arbiter: RTL and testbench

- Per-output-port arbiter of the 2D-mesh XY router; one instance per output direction (L/E/W/N/S).
- Watches the route codes and flits presented by all five input-side controllers and selects, round-robin, those whose code equals this port's PORT_ID.
- Buffers the winning flit in one hold register and pushes it into the downstream output FIFO / link using a write/full handshake.
- Returns a one-cycle grant to the winning input so it can release its flit.

---
 rtl/output_arbiter_pkg.sv | 23 ++
 rtl/output_arbiter_if.sv | 26 ++
 rtl/output_arbiter_rr_pick.sv | 30 +++
 rtl/output_arbiter.sv | 82 ++++++++
 tb/tb_output_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/output_arbiter_pkg.sv
// Shared constants for the mesh router output arbiter: route codes, input
// port indices and the two-state push FSM encoding.
package output_arbiter_pkg;

   localparam logic [2:0] ROUTE_L    = 3'b000;
   localparam logic [2:0] ROUTE_E    = 3'b001;
   localparam logic [2:0] ROUTE_W    = 3'b010;
   localparam logic [2:0] ROUTE_N    = 3'b011;
   localparam logic [2:0] ROUTE_S    = 3'b100;
   localparam logic [2:0] ROUTE_NONE = 3'b111;

   typedef enum logic [2:0] {
      PORT_L = 3'd0,
      PORT_E = 3'd1,
      PORT_W = 3'd2,
      PORT_N = 3'd3,
      PORT_S = 3'd4
   } port_idx_e;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_PUSH = 1'b1;

endpackage

// File: rtl/output_arbiter_if.sv
// Bundle between the input-side controllers, one output arbiter and the
// downstream FIFO/link it feeds.
interface output_arbiter_if #(
   parameter int DATA_WIDTH = 8,
   parameter int N_REGISTER = 3,
   parameter int N_PORT     = 5
);

   logic [N_PORT*N_REGISTER-1:0] route_in;
   logic [N_PORT*DATA_WIDTH-1:0] data_in;
   logic                         full;
   logic [N_PORT-1:0]            grant;
   logic [DATA_WIDTH-1:0]        data_out;
   logic                         write;

   modport master (
      output route_in, data_in, full,
      input  grant, data_out, write
   );

   modport slave (
      input  route_in, data_in, full,
      output grant, data_out, write
   );

endinterface

// File: rtl/output_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping modulo N_PORT.
module output_arbiter_rr_pick #(
   parameter int N_PORT = 5,
   parameter int PTR_W  = $clog2(N_PORT)
) (
   input  logic [N_PORT-1:0] req,
   input  logic [PTR_W-1:0]  ptr,
   output logic [PTR_W-1:0]  winner,
   output logic              any
);

   localparam logic [PTR_W:0] N_PORT_W = (PTR_W+1)'(N_PORT);

   logic [PTR_W:0] idx_s;

   // Scan offsets from farthest to nearest so the nearest request wins last.
   always_comb begin
      winner = '0;
      any    = 1'b0;
      idx_s  = '0;
      for (int off = N_PORT - 1; off >= 0; off--) begin
         idx_s  = {1'b0, ptr} + (PTR_W+1)'(off);
         idx_s  = (idx_s >= N_PORT_W) ? (idx_s - N_PORT_W) : idx_s;
         winner = req[idx_s[PTR_W-1:0]] ? idx_s[PTR_W-1:0] : winner;
         any    = any | req[idx_s[PTR_W-1:0]];
      end
   end

endmodule

// File: rtl/output_arbiter.sv
// Per-output-port arbiter of the XY mesh router: round-robin selects inputs
// routed to PORT_ID, holds one flit and pushes it downstream on !full.
module output_arbiter
   import output_arbiter_pkg::*;
#(
   parameter int                    DATA_WIDTH = 8,
   parameter int                    N_REGISTER = 3,
   parameter int                    N_PORT     = 5,
   parameter logic [N_REGISTER-1:0] PORT_ID    = N_REGISTER'(ROUTE_L)
) (
   input  logic            clk,
   input  logic            rst,
   output_arbiter_if.slave bus
);

   localparam int               PTR_W     = $clog2(N_PORT);
   localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(N_PORT - 1);

   logic [0:0]            state_r;
   logic [PTR_W-1:0]      rr_ptr_r;
   logic [DATA_WIDTH-1:0] hold_r;
   logic [N_PORT-1:0]     grant_r;

   logic [N_PORT-1:0]     req_s;
   logic [PTR_W-1:0]      winner_s;
   logic                  any_s;
   logic                  capture_s;
   logic [DATA_WIDTH-1:0] win_data_s;

   // Request decode: only an exact match on this port's route code counts.
   always_comb begin
      req_s = '0;
      for (int i = 0; i < N_PORT; i++) begin
         req_s[i] = (bus.route_in[i*N_REGISTER +: N_REGISTER] == PORT_ID);
      end
   end

   output_arbiter_rr_pick #(
      .N_PORT (N_PORT),
      .PTR_W  (PTR_W)
   ) u_rr_pick (
      .req    (req_s),
      .ptr    (rr_ptr_r),
      .winner (winner_s),
      .any    (any_s)
   );

   // Flit mux for the selected input.
   always_comb begin
      win_data_s = '0;
      for (int i = 0; i < N_PORT; i++) begin
         win_data_s = (winner_s == PTR_W'(i)) ? bus.data_in[i*DATA_WIDTH +: DATA_WIDTH] : win_data_s;
      end
   end

   // Hold register is free when empty or being drained this cycle.
   assign capture_s    = any_s && ((state_r == ST_IDLE) || !bus.full);
   assign bus.write    = (state_r == ST_PUSH) && !bus.full;
   assign bus.data_out = hold_r;
   assign bus.grant    = grant_r;

   // FSM, hold register, round-robin pointer and single-cycle grant pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         rr_ptr_r <= '0;
         hold_r   <= '0;
         grant_r  <= '0;
      end else if (capture_s) begin
         state_r  <= ST_PUSH;
         hold_r   <= win_data_s;
         grant_r  <= N_PORT'(1) << winner_s;
         rr_ptr_r <= (winner_s == LAST_PORT) ? '0 : (winner_s + PTR_W'(1));
      end else if (bus.write) begin
         state_r  <= ST_IDLE;
         grant_r  <= '0;
      end else begin
         grant_r  <= '0;
      end
   end

endmodule

// File: tb/tb_output_arbiter.sv
// Directed bench for output_arbiter (PORT_ID = E) with an upstream source
// model, a grant scoreboard and a downstream write scoreboard.
module tb_output_arbiter;
   import output_arbiter_pkg::*;

   localparam int         DW  = 8;
   localparam int         NR  = 3;
   localparam int         NP  = 5;
   localparam logic [2:0] PID = ROUTE_E;

   typedef struct packed {
      logic [2:0] idx;
      logic [7:0] flit;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   exp_t       exp_q[$];
   logic [7:0] exp_wr_q[$];
   logic [7:0] src_q[NP][$];
   logic [2:0] idle_code[NP];

   output_arbiter_if #(.DATA_WIDTH(DW), .N_REGISTER(NR), .N_PORT(NP)) bus ();

   output_arbiter #(
      .DATA_WIDTH (DW),
      .N_REGISTER (NR),
      .N_PORT     (NP),
      .PORT_ID    (PID)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Upstream model: an input with a queued flit requests this port.
   task automatic drive();
      for (int i = 0; i < NP; i++) begin
         if (src_q[i].size() > 0) begin
            bus.route_in[i*NR +: NR] = PID;
            bus.data_in[i*DW +: DW]  = src_q[i][0];
         end else begin
            bus.route_in[i*NR +: NR] = idle_code[i];
            bus.data_in[i*DW +: DW]  = 8'hEE;
         end
      end
   endtask

   task automatic cycle();
      exp_t       e;
      logic [7:0] w;
      drive();
      #1;
      if (bus.write === 1'b1) begin
         if (exp_wr_q.size() == 0) begin
            check("write_spurious", 32'(bus.write), 32'd0);
         end else begin
            w = exp_wr_q.pop_front();
            check("write_data", 32'(bus.data_out), 32'(w));
         end
      end
      @(posedge clk);
      #1;
      if (bus.grant !== 5'b00000) begin
         if (exp_q.size() == 0) begin
            check("grant_spurious", 32'(bus.grant), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("grant", 32'(bus.grant), 32'(5'b00001 << e.idx));
            check("grant_data", 32'(bus.data_out), 32'(e.flit));
            exp_wr_q.push_back(e.flit);
         end
         for (int i = 0; i < NP; i++) begin
            if (bus.grant[i] === 1'b1 && src_q[i].size() > 0) w = src_q[i].pop_front();
         end
      end
   endtask

   initial begin
      rst = 1'b1;
      bus.full = 1'b0;
      for (int i = 0; i < NP; i++) idle_code[i] = ROUTE_NONE;
      drive();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state and idle behaviour
      check("reset_state", 32'(dut.state_r), 32'(ST_IDLE));
      check("reset_ptr", 32'(dut.rr_ptr_r), 32'd0);
      for (int c = 0; c < 10; c++) begin
         cycle();
         check("idle_grant", 32'(bus.grant), 32'd0);
         check("idle_write", 32'(bus.write), 32'd0);
         check("idle_data", 32'(bus.data_out), 32'd0);
      end

      // Single request from input 3
      src_q[3].push_back(8'hA5);
      exp_q.push_back({3'd3, 8'hA5});
      cycle();
      check("t2_grant", 32'(bus.grant), 32'h08);
      check("t2_write", 32'(bus.write), 32'd1);
      check("t2_data", 32'(bus.data_out), 32'hA5);
      check("t2_ptr", 32'(dut.rr_ptr_r), 32'd4);
      cycle();
      check("t2_idle_write", 32'(bus.write), 32'd0);
      check("t2_idle_grant", 32'(bus.grant), 32'd0);
      check("t2_keep_data", 32'(bus.data_out), 32'hA5);

      // Pointer wrap, with other route codes present that must be ignored
      idle_code[1] = ROUTE_W;
      idle_code[3] = ROUTE_L;
      src_q[4].push_back(8'h44);
      src_q[0].push_back(8'h0F);
      exp_q.push_back({3'd4, 8'h44});
      exp_q.push_back({3'd0, 8'h0F});
      cycle();
      check("t5_grant_4", 32'(bus.grant), 32'h10);
      check("t5_ptr_0", 32'(dut.rr_ptr_r), 32'd0);
      cycle();
      check("t5_grant_0", 32'(bus.grant), 32'h01);
      check("t5_ptr_1", 32'(dut.rr_ptr_r), 32'd1);
      cycle();
      check("t5_other_codes", 32'(bus.grant), 32'd0);
      check("t5_write_off", 32'(bus.write), 32'd0);
      idle_code[1] = ROUTE_NONE;
      idle_code[3] = ROUTE_NONE;

      rst = 1'b1;
      #1;
      exp_q.delete();
      exp_wr_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      check("t3_ptr_start", 32'(dut.rr_ptr_r), 32'd0);

      // Three continuous requesters, back-to-back grants
      src_q[0].push_back(8'h10); src_q[0].push_back(8'h11);
      src_q[2].push_back(8'h20); src_q[2].push_back(8'h21);
      src_q[4].push_back(8'h40); src_q[4].push_back(8'h41);
      exp_q.push_back({3'd0, 8'h10});
      exp_q.push_back({3'd2, 8'h20});
      exp_q.push_back({3'd4, 8'h40});
      exp_q.push_back({3'd0, 8'h11});
      exp_q.push_back({3'd2, 8'h21});
      exp_q.push_back({3'd4, 8'h41});
      for (int c = 0; c < 6; c++) begin
         cycle();
         check("t3_write", 32'(bus.write), 32'd1);
      end
      check("t3_all_granted", 32'(exp_q.size()), 32'd0);
      cycle();
      check("t3_drain_grant", 32'(bus.grant), 32'd0);

      // Back-pressure: full holds the flit and blocks new captures
      src_q[0].push_back(8'h3C);
      exp_q.push_back({3'd0, 8'h3C});
      cycle();
      check("t4_data", 32'(bus.data_out), 32'h3C);
      bus.full = 1'b1;
      src_q[1].push_back(8'h5A);
      exp_q.push_back({3'd1, 8'h5A});
      for (int c = 0; c < 4; c++) begin
         cycle();
         check("t4_full_write", 32'(bus.write), 32'd0);
         check("t4_full_data", 32'(bus.data_out), 32'h3C);
         check("t4_full_grant", 32'(bus.grant), 32'd0);
      end
      bus.full = 1'b0;
      #1;
      check("t4_release_write", 32'(bus.write), 32'd1);
      cycle();
      check("t4_grant_1", 32'(bus.grant), 32'h02);
      cycle();
      check("t4_idle_write", 32'(bus.write), 32'd0);

      // Reset while a flit is pending behind full
      src_q[2].push_back(8'h77);
      exp_q.push_back({3'd2, 8'h77});
      bus.full = 1'b1;
      cycle();
      check("t6_grant", 32'(bus.grant), 32'h04);
      check("t6_write_blocked", 32'(bus.write), 32'd0);
      cycle();
      check("t6_state_push", 32'(dut.state_r), 32'(ST_PUSH));
      check("t6_hold", 32'(bus.data_out), 32'h77);
      rst = 1'b1;
      bus.full = 1'b0;
      #1;
      check("t6_rst_write", 32'(bus.write), 32'd0);
      check("t6_rst_data", 32'(bus.data_out), 32'd0);
      exp_wr_q.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cycle();
         check("t6_post_write", 32'(bus.write), 32'd0);
         check("t6_post_data", 32'(bus.data_out), 32'd0);
         check("t6_post_grant", 32'(bus.grant), 32'd0);
      end
      check("t6_state_idle", 32'(dut.state_r), 32'(ST_IDLE));

      check("grants_pending", 32'(exp_q.size()), 32'd0);
      check("writes_pending", 32'(exp_wr_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
